// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
// dense_layer_sequencer
// Walks an SDRAM descriptor table and runs a dense controller one layer at a time.
// Rev 1.0
// ============================================================================
module dense_layer_sequencer #(
  parameter int LAYER_W   = 8,
  parameter int TIMEOUT_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic [2:0]  dense_address,
  output logic        dense_write,
  output logic [31:0] dense_writedata,
  output logic        dense_read,
  input  logic [31:0] dense_readdata,
  input  logic        dense_waitrequest,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PROG, S_START, S_WAITD, S_NEXT, S_DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] c_WD_LIMIT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               r_state;
  logic [31:0]          r_table_base;
  logic [LAYER_W-1:0]   r_layer_count;
  logic [LAYER_W-1:0]   r_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 r_abort_pending;
  logic [2:0]           r_k;
  logic [31:0]          r_desc [0:4];
  logic [TIMEOUT_W-1:0] r_wd;

  logic                 w_start;
  logic                 w_abort;
  logic [LAYER_W:0]     w_idx_inc;
  logic [31:0]          w_next_desc_addr;
  logic                 w_unused_rdata;

  assign w_start          = slave_write && (slave_address == 3'd0) && slave_writedata[0];
  assign w_abort          = slave_write && (slave_address == 3'd0) && slave_writedata[1];
  assign w_idx_inc        = {1'b0, r_idx} + {{LAYER_W{1'b0}}, 1'b1};
  assign w_next_desc_addr = r_table_base + 32'(w_idx_inc[LAYER_W-1:0]) * 32'd20;
  assign w_unused_rdata   = ^dense_readdata;

  assign slave_waitrequest = 1'b0;
  assign irq               = r_done;

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        3'd1:    slave_readdata = r_table_base;
        3'd2:    slave_readdata = 32'(r_layer_count);
        3'd3:    slave_readdata = {29'b0, r_error, r_done, r_busy};
        3'd4:    slave_readdata = 32'(r_idx);
        default: slave_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_table_base    <= '0;
      r_layer_count   <= '0;
      r_idx           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_abort_pending <= 1'b0;
      r_k             <= '0;
      r_wd            <= '0;
      for (int i = 0; i < 5; i++) r_desc[i] <= '0;
      mem_address     <= '0;
      mem_read        <= 1'b0;
      dense_address   <= '0;
      dense_write     <= 1'b0;
      dense_writedata <= '0;
      dense_read      <= 1'b0;
    end else begin
      if (slave_write && !r_busy) begin
        if (slave_address == 3'd1) r_table_base  <= slave_writedata;
        if (slave_address == 3'd2) r_layer_count <= slave_writedata[LAYER_W-1:0];
      end
      if (slave_write && (slave_address == 3'd3)) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      // Abort is only latched here; the layer in flight always runs to completion.
      if (w_abort && r_busy) begin
        r_abort_pending <= 1'b1;
        r_error         <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_abort_pending <= 1'b0;
            r_idx           <= '0;
            if (r_layer_count == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy      <= 1'b1;
              r_k         <= '0;
              mem_read    <= 1'b1;
              mem_address <= r_table_base;
              r_state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (!mem_waitrequest) begin
            r_desc[r_k] <= mem_readdata;
            if (r_k == 3'd4) begin
              mem_read        <= 1'b0;
              r_k             <= '0;
              dense_write     <= 1'b1;
              dense_address   <= 3'd1;
              dense_writedata <= r_desc[0];
              r_state         <= S_PROG;
            end else begin
              r_k         <= r_k + 3'd1;
              mem_address <= mem_address + 32'd4;
            end
          end
        end
        S_PROG: begin
          if (!dense_waitrequest) begin
            if (r_k == 3'd4) begin
              dense_address   <= 3'd0;
              dense_writedata <= 32'd1;
              r_state         <= S_START;
            end else begin
              r_k             <= r_k + 3'd1;
              dense_address   <= r_k + 3'd2;
              dense_writedata <= r_desc[r_k + 3'd1];
            end
          end
        end
        S_START: begin
          if (!dense_waitrequest) begin
            dense_write     <= 1'b0;
            dense_writedata <= '0;
            dense_read      <= 1'b1;
            dense_address   <= 3'd0;
            r_wd            <= '0;
            r_state         <= S_WAITD;
          end
        end
        S_WAITD: begin
          if (!dense_waitrequest) begin
            dense_read <= 1'b0;
            r_state    <= S_NEXT;
          end else if (r_wd == c_WD_LIMIT) begin
            dense_read      <= 1'b0;
            r_error         <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
            r_abort_pending <= 1'b0;
            r_state         <= S_DONE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_NEXT: begin
          if ((w_idx_inc == {1'b0, r_layer_count}) || r_abort_pending) begin
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
            r_abort_pending <= 1'b0;
            r_state         <= S_DONE;
          end else begin
            r_idx       <= w_idx_inc[LAYER_W-1:0];
            r_k         <= '0;
            mem_read    <= 1'b1;
            mem_address <= w_next_desc_addr;
            r_state     <= S_FETCH;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_sequencer.sv
`default_nettype none
// Bench: SDRAM and dense-controller responders, transaction-level expectation queues, directed scenarios.
module tb_dense_layer_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  slave_address;
  logic        slave_read, slave_write, slave_waitrequest;
  logic [31:0] slave_writedata, slave_readdata;
  logic [31:0] mem_address, mem_readdata;
  logic        mem_read, mem_waitrequest;
  logic [2:0]  dense_address;
  logic        dense_write, dense_read, dense_waitrequest;
  logic [31:0] dense_writedata, dense_readdata;
  logic        irq;

  logic [2:0]  wd_slave_address;
  logic        wd_slave_read, wd_slave_write, wd_slave_waitrequest;
  logic [31:0] wd_slave_writedata, wd_slave_readdata;
  logic [31:0] wd_mem_address, wd_mem_readdata;
  logic        wd_mem_read, wd_mem_waitrequest;
  logic [2:0]  wd_dense_address;
  logic        wd_dense_write, wd_dense_read, wd_dense_waitrequest;
  logic [31:0] wd_dense_writedata, wd_dense_readdata;
  logic        wd_irq;

  dense_layer_sequencer #(.LAYER_W(8), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .dense_address(dense_address), .dense_write(dense_write), .dense_writedata(dense_writedata),
    .dense_read(dense_read), .dense_readdata(dense_readdata), .dense_waitrequest(dense_waitrequest),
    .irq(irq)
  );

  dense_layer_sequencer #(.LAYER_W(8), .TIMEOUT_W(4)) dut_wd (
    .clk(clk), .reset(reset),
    .slave_address(wd_slave_address), .slave_read(wd_slave_read), .slave_readdata(wd_slave_readdata),
    .slave_write(wd_slave_write), .slave_writedata(wd_slave_writedata),
    .slave_waitrequest(wd_slave_waitrequest),
    .mem_address(wd_mem_address), .mem_read(wd_mem_read), .mem_readdata(wd_mem_readdata),
    .mem_waitrequest(wd_mem_waitrequest),
    .dense_address(wd_dense_address), .dense_write(wd_dense_write),
    .dense_writedata(wd_dense_writedata), .dense_read(wd_dense_read),
    .dense_readdata(wd_dense_readdata), .dense_waitrequest(wd_dense_waitrequest),
    .irq(wd_irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    $display("FAIL %s: %s", name, why);
  endtask

  // SDRAM contents: explicit entries, otherwise a pattern derived from the address
  logic [31:0] mem_model [logic [31:0]];
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Expected transactions; dense entries are {is_write, address, data}
  logic [31:0] exp_mem   [$];
  logic [35:0] exp_dense [$];
  logic [31:0] mem_log   [$];
  logic [35:0] dense_log [$];

  task automatic build_expect(input logic [31:0] base, input int layers);
    for (int i = 0; i < layers; i++) begin
      for (int k = 0; k < 5; k++) exp_mem.push_back(base + 32'(20 * i + 4 * k));
      for (int k = 0; k < 5; k++)
        exp_dense.push_back({1'b1, 3'(k + 1), mem_val(base + 32'(20 * i + 4 * k))});
      exp_dense.push_back({1'b1, 3'd0, 32'd1});
      exp_dense.push_back({1'b0, 3'd0, 32'd0});
    end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_mem_pending"},   64'(exp_mem.size()),   64'd0);
    check({tag, "_dense_pending"}, 64'(exp_dense.size()), 64'd0);
  endtask

  int stall_en   = 0;
  int dense_hold = 0;

  // Slave responders: stalls are drawn once per request and the request then completes
  initial begin
    int  mem_left, d_left;
    bit  mem_pend, d_pend;
    mem_waitrequest = 1'b0; mem_readdata = '0; dense_waitrequest = 1'b0; dense_readdata = '0;
    wd_mem_waitrequest = 1'b0; wd_mem_readdata = 32'h77; wd_dense_waitrequest = 1'b0;
    wd_dense_readdata = '0;
    mem_left = 0; d_left = 0; mem_pend = 0; d_pend = 0;
    forever begin
      @(negedge clk);
      if (mem_read) begin
        if (!mem_pend) begin
          mem_pend = 1;
          mem_left = (stall_en != 0) ? int'($urandom_range(0, 3)) : 0;
        end
        mem_waitrequest = (mem_left != 0);
        if (mem_left != 0) mem_left--; else mem_pend = 0;
      end else begin
        mem_waitrequest = 1'b0;
        mem_pend = 0;
      end
      mem_readdata = mem_val(mem_address);
      if (dense_write || dense_read) begin
        if (!d_pend) begin
          d_pend = 1;
          d_left = dense_read ? dense_hold : ((stall_en != 0) ? int'($urandom_range(0, 2)) : 0);
        end
        dense_waitrequest = (d_left != 0);
        if (d_left != 0) d_left--; else d_pend = 0;
      end else begin
        dense_waitrequest = 1'b0;
        d_pend = 0;
      end
      wd_dense_waitrequest = wd_dense_read;
    end
  end

  // Compare process: hold rule on stalled strobes and every completed transfer against the queues
  initial begin
    bit          p_valid;
    logic        p_mrd, p_mwait, p_dw, p_dr, p_dwait;
    logic [31:0] p_maddr, p_ddata;
    logic [2:0]  p_daddr;
    logic [35:0] got;
    p_valid = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        p_valid = 0;
      end else begin
        if (p_valid && p_mrd && p_mwait)
          check("mem_hold", {mem_read, mem_address}, {1'b1, p_maddr});
        if (p_valid && (p_dw || p_dr) && p_dwait)
          check("dense_hold", {dense_write, dense_read, dense_address, dense_writedata},
                {p_dw, p_dr, p_daddr, p_ddata});
        if (mem_read && !mem_waitrequest) begin
          mem_log.push_back(mem_address);
          if (exp_mem.size() == 0) fail_now("mem_extra", $sformatf("read 0x%0h, none expected", mem_address));
          else check("mem_addr", mem_address, exp_mem.pop_front());
        end
        if ((dense_write || dense_read) && !dense_waitrequest) begin
          got = {dense_write, dense_address, dense_write ? dense_writedata : 32'd0};
          dense_log.push_back(got);
          if (exp_dense.size() == 0) fail_now("dense_extra", $sformatf("xfer 0x%0h, none expected", got));
          else check("dense_xfer", got, exp_dense.pop_front());
        end
        p_valid = 1;
      end
      p_mrd = mem_read; p_mwait = mem_waitrequest; p_maddr = mem_address;
      p_dw = dense_write; p_dr = dense_read; p_dwait = dense_waitrequest;
      p_daddr = dense_address; p_ddata = dense_writedata;
    end
  end

  task automatic cpu_write(input bit to_wd, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    if (to_wd) begin
      wd_slave_address = a; wd_slave_writedata = d; wd_slave_write = 1'b1;
    end else begin
      slave_address = a; slave_writedata = d; slave_write = 1'b1;
    end
    @(negedge clk);
    slave_write = 1'b0;
    wd_slave_write = 1'b0;
  endtask

  task automatic cpu_read(input bit to_wd, input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    if (to_wd) begin wd_slave_address = a; wd_slave_read = 1'b1; end
    else begin slave_address = a; slave_read = 1'b1; end
    #2;
    d = to_wd ? wd_slave_readdata : slave_readdata;
    slave_read = 1'b0;
    wd_slave_read = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int budget);
    for (int i = 0; i < budget && !irq; i++) @(negedge clk);
    if (!irq) fail_now(name, $sformatf("irq not raised within %0d cycles", budget));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] rd;
    int          cnt, n_mem, n_dense;
    reset = 1'b0;
    slave_address = '0; slave_read = 0; slave_write = 0; slave_writedata = '0;
    wd_slave_address = '0; wd_slave_read = 0; wd_slave_write = 0; wd_slave_writedata = '0;
    mem_model[32'h1000] = 32'h100; mem_model[32'h1004] = 32'h200; mem_model[32'h1008] = 32'h300;
    mem_model[32'h100C] = 32'h400; mem_model[32'h1010] = 32'd4;

    repeat (3) @(negedge clk);
    #1;
    check("reset_strobes", {mem_read, dense_write, dense_read, irq, slave_waitrequest}, 5'b0);
    check("reset_addrs", {mem_address, dense_address}, 35'd0);
    reset = 1'b1;
    cpu_read(0, 3'd3, rd); check("reset_status", rd, 0);
    cpu_read(0, 3'd2, rd); check("reset_layer_count", rd, 0);

    // One layer, no stalls
    cpu_write(0, 3'd1, 32'h1000);
    cpu_write(0, 3'd2, 32'd1);
    cpu_read(0, 3'd1, rd); check("table_base_rw", rd, 32'h1000);
    #1 check("readdata_not_reading", slave_readdata, 0);
    dense_log.delete();
    build_expect(32'h1000, 1);
    cpu_write(0, 3'd0, 32'd1);
    cpu_read(0, 3'd3, rd); check("status_busy", rd, 32'd1);
    wait_irq("irq_1layer", 100);
    cpu_read(0, 3'd3, rd); check("status_done_1layer", rd, 32'd2);
    cpu_read(0, 3'd4, rd); check("cur_layer_1layer", rd, 0);
    check_drained("1layer");
    check("log_reg1", dense_log[0], {1'b1, 3'd1, 32'h100});
    check("log_reg4", dense_log[3], {1'b1, 3'd4, 32'h400});
    check("log_reg5", dense_log[4], {1'b1, 3'd5, 32'd4});
    check("log_start", dense_log[5], {1'b1, 3'd0, 32'd1});
    check("log_read", dense_log[6], {1'b0, 3'd0, 32'd0});

    // Three layers with random stalls
    cpu_write(0, 3'd3, 32'd0);
    check("irq_cleared", irq, 1'b0);
    stall_en = 1;
    mem_log.delete();
    build_expect(32'h1000, 3);
    cpu_write(0, 3'd2, 32'd3);
    cpu_write(0, 3'd0, 32'd1);
    wait_irq("irq_3layer", 600);
    stall_en = 0;
    check("mem_count_3layer", 64'(mem_log.size()), 64'd15);
    check("mem_first", mem_log[0], 32'h1000);
    check("mem_last", mem_log[14], 32'h1038);
    cpu_read(0, 3'd4, rd); check("cur_layer_3layer", rd, 32'd2);
    cpu_read(0, 3'd3, rd); check("status_done_3layer", rd, 32'd2);
    check_drained("3layer");

    // Zero layers: done immediately, no bus activity
    cpu_write(0, 3'd3, 32'd0);
    cpu_write(0, 3'd2, 32'd0);
    n_mem = mem_log.size(); n_dense = dense_log.size();
    cpu_write(0, 3'd0, 32'd1);
    check("irq_zero_layers", irq, 1'b1);
    repeat (5) @(negedge clk);
    cpu_read(0, 3'd3, rd); check("status_zero_layers", rd, 32'd2);
    check("no_mem_zero_layers", 64'(mem_log.size()), 64'(n_mem));
    check("no_dense_zero_layers", 64'(dense_log.size()), 64'(n_dense));
    cpu_write(0, 3'd3, 32'd5);
    check("irq_after_clear", irq, 1'b0);

    // Abort during a long layer 0 of 3
    dense_hold = 50;
    cpu_write(0, 3'd1, 32'h2000);
    cpu_write(0, 3'd2, 32'd3);
    build_expect(32'h2000, 1);
    cpu_write(0, 3'd0, 32'd1);
    cnt = 0;
    while (!dense_read && cnt < 100) begin @(negedge clk); cnt++; end
    if (!dense_read) fail_now("abort_wait_read", "dense_read never asserted");
    repeat (10) @(negedge clk);
    cpu_write(0, 3'd1, 32'hFFFF);
    cpu_write(0, 3'd0, 32'd2);
    cpu_read(0, 3'd1, rd); check("base_write_ignored_busy", rd, 32'h2000);
    cpu_read(0, 3'd3, rd); check("status_abort_pending", rd, 32'd5);
    wait_irq("irq_abort", 200);
    dense_hold = 0;
    repeat (3) @(negedge clk);
    cpu_read(0, 3'd3, rd); check("status_abort", rd, 32'd6);
    cpu_read(0, 3'd4, rd); check("cur_layer_abort", rd, 0);
    check_drained("abort");
    cpu_write(0, 3'd3, 32'd0);

    // Watchdog with a 4-bit timer
    cpu_write(1, 3'd1, 32'h40);
    cpu_write(1, 3'd2, 32'd1);
    cpu_write(1, 3'd0, 32'd1);
    cnt = 0;
    while (!wd_dense_read && cnt < 100) begin @(negedge clk); cnt++; end
    if (!wd_dense_read) fail_now("wd_wait_read", "dense_read never asserted");
    cnt = 0;
    while (wd_dense_read && cnt < 100) begin cnt++; @(negedge clk); end
    check("wd_read_cycles", 64'(cnt), 64'd15);
    check("wd_irq", wd_irq, 1'b1);
    cpu_read(1, 3'd3, rd); check("wd_status", rd, 32'd6);

    // Asynchronous reset in the middle of programming
    cpu_write(0, 3'd1, 32'h3000);
    cpu_write(0, 3'd2, 32'd2);
    build_expect(32'h3000, 2);
    cpu_write(0, 3'd0, 32'd1);
    cnt = 0;
    while (!(dense_write && dense_address == 3'd3) && cnt < 100) begin @(negedge clk); cnt++; end
    if (!dense_write) fail_now("rst_wait_prog", "dense_write never asserted");
    #2 reset = 1'b0;
    #1;
    check("rst_strobes", {mem_read, dense_write, dense_read, irq}, 4'b0);
    slave_address = 3'd3; slave_read = 1'b1;
    #1 check("rst_status", slave_readdata, 0);
    slave_read = 1'b0;
    @(negedge clk);
    exp_mem.delete();
    exp_dense.delete();
    reset = 1'b1;
    cpu_read(0, 3'd1, rd); check("rst_table_base", rd, 0);
    cpu_write(0, 3'd1, 32'h3000);
    cpu_write(0, 3'd2, 32'd1);
    build_expect(32'h3000, 1);
    cpu_write(0, 3'd0, 32'd1);
    wait_irq("irq_after_reset", 100);
    cpu_read(0, 3'd3, rd); check("status_after_reset", rd, 32'd2);
    check_drained("after_reset");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
